// File: rtl/vreg_file_v2.sv
// ---------------------------------------------------------------------------
// vreg_file_v2 -- RVV vector register file with CSR state and scoreboard
//
// NREG registers of VLEN bits, two combinational read ports, one element-
// masked write port (tail-undisturbed past vl, mask-undisturbed under v0),
// the vsetvl CSR state (vl, vtype, vill, AVL) and a per-register
// pending-write scoreboard.
//
// Parameters: VLEN (register width, pow2 >= 64), NREG (pow2), XLEN (AVL width)
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-low reset
//   raA, raB / rdA, rdB  read addresses / read data
//   wen, wa, wd          write enable, address, data
//   wmask_en             apply v0 mask to this write
//   cfg_valid, avl_in,   vsetvl request: requested AVL and vtype
//   vtype_in               ([6] valid, [5:3] vsew, [2:0] vlmul)
//   vl, vtype, vill,     current CSR state
//   avl_reg
//   issue_valid,         mark issue_vd as pending a write
//   issue_vd
//   busyA, busyB         pending write on raA / raB (registered, no bypass)
//
// Build option: define VREG_BYPASS_EN to forward a same-cycle write onto the
// read ports (merged post-write value). Without it reads show the array.
// ---------------------------------------------------------------------------
module vreg_file_v2 #(
    parameter int VLEN = 128,
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NREG)-1:0]     raA,
    input  logic [$clog2(NREG)-1:0]     raB,
    output logic [VLEN-1:0]             rdA,
    output logic [VLEN-1:0]             rdB,
    input  logic                        wen,
    input  logic [$clog2(NREG)-1:0]     wa,
    input  logic [VLEN-1:0]             wd,
    input  logic                        wmask_en,
    input  logic                        cfg_valid,
    input  logic [XLEN-1:0]             avl_in,
    input  logic [6:0]                  vtype_in,
    output logic [$clog2(VLEN/8):0]     vl,
    output logic [6:0]                  vtype,
    output logic                        vill,
    output logic [XLEN-1:0]             avl_reg,
    input  logic                        issue_valid,
    input  logic [$clog2(NREG)-1:0]     issue_vd,
    output logic                        busyA,
    output logic                        busyB
);

    localparam int NBYTE = VLEN / 8;
    localparam int VLW   = $clog2(VLEN / 8) + 1;
    localparam int IW    = $clog2(VLEN);

    logic [VLEN-1:0]  regs [NREG];
    logic [NREG-1:0]  busy;
    logic [NBYTE-1:0] ben;
    logic [VLEN-1:0]  merged;

    // vsetvl decode
    logic            cfg_legal;
    logic [XLEN-1:0] vlmax_in;
    logic [VLW-1:0]  vl_new;

    always_comb begin
        cfg_legal = vtype_in[6] && (vtype_in[5:3] <= 3'd3) && (vtype_in[2:0] == 3'b000);
        vlmax_in  = XLEN'(NBYTE) >> vtype_in[5:3];
        // Compare at full AVL width so large AVLs saturate rather than wrap.
        if (avl_in < vlmax_in)
            vl_new = avl_in[VLW-1:0];
        else
            vl_new = vlmax_in[VLW-1:0];
    end

    // Per-byte write enables: byte b belongs to element b >> vsew. The mask
    // is taken from the stored v0, so a masked write to v0 sees its old value.
    // An illegal vtype forces vl = 0, which disables every byte.
    always_comb begin
        ben = '0;
        for (int unsigned b = 0; b < NBYTE; b++) begin
            logic [IW-1:0] e;
            e = IW'(b) >> vtype[5:3];
            if ((e < IW'(vl)) && (!wmask_en || regs[0][e]))
                ben[b] = 1'b1;
        end
    end

    always_comb begin
        merged = regs[wa];
        for (int unsigned b = 0; b < NBYTE; b++) begin
            if (ben[b])
                merged[8*b +: 8] = wd[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++)
                regs[r] <= '0;
            vl      <= '0;
            vtype   <= '0;
            vill    <= 1'b0;
            avl_reg <= '0;
            busy    <= '0;
        end else begin
            // Uses pre-update vl/vtype even when cfg_valid is also asserted.
            if (wen)
                regs[wa] <= merged;

            if (cfg_valid) begin
                avl_reg <= avl_in;
                if (cfg_legal) begin
                    vtype <= vtype_in;
                    vill  <= 1'b0;
                    vl    <= vl_new;
                end else begin
                    vtype <= '0;
                    vill  <= 1'b1;
                    vl    <= '0;
                end
            end

            // Set after clear so a same-register issue wins over writeback.
            begin
                logic [NREG-1:0] busy_n;
                busy_n = busy;
                if (wen)
                    busy_n[wa] = 1'b0;
                if (issue_valid)
                    busy_n[issue_vd] = 1'b1;
                busy <= busy_n;
            end
        end
    end

    always_comb begin
        rdA = regs[raA];
        rdB = regs[raB];
`ifdef VREG_BYPASS_EN
        if (rst && wen && (wa == raA))
            rdA = merged;
        if (rst && wen && (wa == raB))
            rdB = merged;
`else
`endif
    end

    assign busyA = busy[raA];
    assign busyB = busy[raB];

endmodule

// File: tb/tb_vreg_file_v2.sv
// ---------------------------------------------------------------------------
// tb_vreg_file_v2 -- self-checking bench for vreg_file_v2
//
// Directed scenarios followed by randomized traffic, checked against an
// element-level reference model of the register file, CSRs and scoreboard.
// ---------------------------------------------------------------------------
module tb_vreg_file_v2;

    localparam int VLEN  = 128;
    localparam int NREG  = 32;
    localparam int XLEN  = 32;
    localparam int NBYTE = VLEN / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       raA, raB, wa, issue_vd;
    logic [VLEN-1:0]  rdA, rdB, wd;
    logic             wen, wmask_en, cfg_valid, issue_valid;
    logic [XLEN-1:0]  avl_in, avl_reg;
    logic [6:0]       vtype_in, vtype;
    logic [4:0]       vl;
    logic             vill, busyA, busyB;

    vreg_file_v2 #(.VLEN(VLEN), .NREG(NREG), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .raA(raA), .raB(raB), .rdA(rdA), .rdB(rdB),
        .wen(wen), .wa(wa), .wd(wd), .wmask_en(wmask_en),
        .cfg_valid(cfg_valid), .avl_in(avl_in), .vtype_in(vtype_in),
        .vl(vl), .vtype(vtype), .vill(vill), .avl_reg(avl_reg),
        .issue_valid(issue_valid), .issue_vd(issue_vd),
        .busyA(busyA), .busyB(busyB)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [VLEN-1:0] m_regs [NREG];
    int unsigned     m_vl;
    logic [6:0]      m_vtype;
    logic            m_vill;
    logic [XLEN-1:0] m_avl;
    logic [NREG-1:0] m_busy;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Register a after an element-wise write of d under the current model CSRs.
    function automatic logic [VLEN-1:0] model_write(input logic [4:0] a, input logic [VLEN-1:0] d, input logic mk);
        logic [VLEN-1:0] r;
        int unsigned es;
        r  = m_regs[a];
        es = 1 << m_vtype[5:3];
        for (int unsigned e = 0; e < m_vl; e++)
            if (!mk || m_regs[0][e])
                for (int unsigned k = 0; k < es; k++)
                    r[8*(e*es+k) +: 8] = d[8*(e*es+k) +: 8];
        return r;
    endfunction

    function automatic logic [VLEN-1:0] model_read(input logic [4:0] a);
`ifdef VREG_BYPASS_EN
        if (rst && wen && wa == a)
            return model_write(wa, wd, wmask_en);
`endif
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (!rst) begin
            for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            m_vl = 0; m_vtype = '0; m_vill = 1'b0; m_avl = '0; m_busy = '0;
        end else begin
            logic [VLEN-1:0] nv;
            nv = model_write(wa, wd, wmask_en);
            if (wen) begin
                m_regs[wa] = nv;
                m_busy[wa] = 1'b0;
            end
            if (issue_valid) m_busy[issue_vd] = 1'b1;
            if (cfg_valid) begin
                m_avl = avl_in;
                if (vtype_in[6] && vtype_in[5:3] <= 3 && vtype_in[2:0] == 0) begin
                    int unsigned vlmax;
                    vlmax   = VLEN / (8 << vtype_in[5:3]);
                    m_vl    = (avl_in < vlmax) ? avl_in : vlmax;
                    m_vtype = vtype_in;
                    m_vill  = 1'b0;
                end else begin
                    m_vl = 0; m_vtype = '0; m_vill = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("rdA",     rdA, model_read(raA));
        check("rdB",     rdB, model_read(raB));
        check("busyA",   VLEN'(busyA), VLEN'(m_busy[raA]));
        check("busyB",   VLEN'(busyB), VLEN'(m_busy[raB]));
        check("vl",      VLEN'(vl), VLEN'(m_vl));
        check("vtype",   VLEN'(vtype), VLEN'(m_vtype));
        check("vill",    VLEN'(vill), VLEN'(m_vill));
        check("avl_reg", VLEN'(avl_reg), VLEN'(m_avl));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wen = 0; cfg_valid = 0; issue_valid = 0; wmask_en = 0;
    endtask

    task automatic do_cfg(input logic [XLEN-1:0] avl, input logic [6:0] vt);
        idle(); cfg_valid = 1; avl_in = avl; vtype_in = vt;
        step(); idle();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [VLEN-1:0] d, input logic mk);
        idle(); wen = 1; wa = a; wd = d; wmask_en = mk;
        step(); idle();
    endtask

    initial begin
        rst = 0; raA = 0; raB = 0; wa = 0; wd = '0; issue_vd = 0;
        avl_in = '0; vtype_in = '0;
        idle();
        step(); step();
        rst = 1;

        // Reset contents of every register
        for (int i = 0; i < NREG; i++) begin
            raA = 5'(i); raB = 5'(NREG - 1 - i);
            step();
            check("rst_reg", rdA, '0);
        end
        check("rst_vl", VLEN'(vl), '0);
        check("rst_busy", VLEN'({busyA, busyB}), '0);

        // vsetvl behaviour
        do_cfg(100, 7'b1_010_000);
        check("vl_sew32_avl100", VLEN'(vl), 4);
        do_cfg(3, 7'b1_010_000);
        check("vl_avl3", VLEN'(vl), 3);
        do_cfg(3, 7'b1_101_000);
        check("vill_sew5", VLEN'({vill, vl}), VLEN'({1'b1, 5'd0}));
        do_cfg(32'h8000_0002, 7'b1_011_000);
        check("vl_big_avl", VLEN'(vl), 2);

        // Tail-undisturbed at vl = 3, SEW32
        do_cfg(16, 7'b1_000_000);
        do_write(5, '1, 0);
        do_cfg(3, 7'b1_010_000);
        do_write(5, '0, 0);
        raA = 5;
        #1 check("tail_v5", rdA, {32'hFFFF_FFFF, 96'h0});

        // Mask-undisturbed at vl = 16, SEW8, v0 = 0x00FF
        do_cfg(16, 7'b1_000_000);
        do_write(0, VLEN'(16'h00FF), 0);
        do_write(7, '1, 0);
        do_write(7, '0, 1);
        raA = 7;
        #1 check("mask_v7", rdA, {{64{1'b1}}, 64'h0});

        // Write with vill set is a no-op
        do_cfg(4, 7'b0_000_000);
        do_write(7, '0, 0);
        #1 check("vill_nowrite", rdA, {{64{1'b1}}, 64'h0});
        do_cfg(16, 7'b1_000_000);

        // Scoreboard
        raA = 9; raB = 9;
        issue_valid = 1; issue_vd = 9;
        #1 check("busy_no_bypass", VLEN'(busyA), 0);
        step(); idle();
        check("busy_set", VLEN'(busyA), 1);
        wen = 1; wa = 9; wd = $urandom; issue_valid = 1; issue_vd = 9;
        step(); idle();
        check("busy_set_wins", VLEN'(busyA), 1);
        wen = 1; wa = 9;
        step(); idle();
        check("busy_clear", VLEN'(busyA), 0);

        // Read-after-write in the same cycle
        do_write(4, {4{32'h1234_5678}}, 0);
        raA = 4; wen = 1; wa = 4; wd = {16{8'hA5}}; wmask_en = 0;
        #1;
`ifdef VREG_BYPASS_EN
        check("raw_same_cycle", rdA, {16{8'hA5}});
`else
        check("raw_same_cycle", rdA, {4{32'h1234_5678}});
`endif
        step(); idle();
        check("raw_next_cycle", rdA, {16{8'hA5}});

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) != 0);
            raA         = 5'($urandom); raB = 5'($urandom);
            wen         = ($urandom_range(0, 1) == 1);
            wa          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 3) == 0) raA = wa;
            wd          = {$urandom, $urandom, $urandom, $urandom};
            wmask_en    = ($urandom_range(0, 1) == 1);
            cfg_valid   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       avl_in = $urandom;
                default: avl_in = $urandom_range(0, 20);
            endcase
            if ($urandom_range(0, 3) != 0)
                vtype_in = {1'b1, 3'($urandom_range(0, 3)), 3'b000};
            else
                vtype_in = 7'($urandom);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_vd    = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
            #1 check("rnd_comb_rdA", rdA, model_read(raA));
            step();
        end
        rst = 1; idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vreg_file_v2.md
# vreg_file_v2

Parametrised vector register file for the RVV datapath: NREG registers of VLEN bits, two read ports, one element-masked write port, the vector CSR state (vl, vtype, vill, AVL) and a per-register pending-write scoreboard. It sits between decode/issue, which reads operands, issues vsetvl and marks destinations busy, and the vector ALU writeback stage. Writes honour vl (tail-undisturbed) and optional v0 masking (mask-undisturbed).

## Interface
- VLEN, 128, register width in bits; power of two, ≥64
- NREG, 32, register count; power of two
- XLEN, 32, AVL width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- raA, raB  in  log2(NREG)  read addresses
- rdA, rdB  out  VLEN  read data
- wen  in  1  write enable
- wa  in  log2(NREG)  write address
- wd  in  VLEN  write data
- wmask_en  in  1  1 = apply v0 mask to this write
- cfg_valid  in  1  vsetvl request
- avl_in  in  XLEN  requested AVL
- vtype_in  in  7  [6] valid, [5:3] vsew, [2:0] vlmul
- vl  out  log2(VLEN/8)+1  current vl
- vtype  out  7  current vtype
- vill  out  1  illegal vtype flag
- avl_reg  out  XLEN  last accepted AVL
- issue_valid  in  1  mark issue_vd pending
- issue_vd  in  log2(NREG)  destination being issued
- busyA, busyB  out  1  pending write on raA / raB

## Operation
- SEW = 8 << vsew. VLMAX = VLEN/SEW. Legal vtype: vtype_in[6]=1, vsew ≤ 3, vlmul = 000.
- cfg_valid with legal vtype: vtype ← vtype_in, vill ← 0, avl_reg ← avl_in, vl ← min(avl_in, VLMAX); full XLEN compare, no truncation before the min.
- cfg_valid with illegal vtype: vill ← 1, vtype ← 0, vl ← 0, avl_reg ← avl_in.
- No cfg_valid: all CSR state holds.
- Write: byte b of wa is updated only if element e = b / (SEW/8) satisfies e < vl and (wmask_en = 0 or v0[e] = 1). Otherwise the byte keeps its old value. vill = 1 or vl = 0 makes the write a no-op to data.
- Mask source is the registered v0. A write to v0 itself with wmask_en = 1 uses the old v0.
- Scoreboard: issue_valid sets busy[issue_vd]. wen clears busy[wa], regardless of the mask result. When both target the same register in the same cycle, the set wins. busyA = busy[raA], busyB = busy[raB].
- Reads are combinational from the array.

## Timing
- Reset (rst = 0 at posedge) clears:
  - all registers to 0
  - vl = 0, vtype = 0, vill = 0, avl_reg = 0
  - all busy bits
  - This applies even mid-operation; wen, cfg_valid and issue_valid are ignored in that cycle.
- Writes, CSR updates and scoreboard changes land at the posedge and are visible the following cycle.
- wen together with cfg_valid: the write uses the pre-update vl and vtype.
- Read-after-write in the same cycle: see Configuration.
- busy outputs do not bypass; an issue_valid is visible on busyA/busyB one cycle later.

## Configuration
- VREG_BYPASS_EN defined: if wen and wa == raA, rdA returns the merged post-write value (masked/tail bytes from the array, updated bytes from wd). rdB behaves the same way.
- VREG_BYPASS_EN undefined: rdA and rdB return the array contents and show the write one cycle later.

## Test plan
- Reset, then read all registers → all 0; vl = 0, vill = 0, busyA = busyB = 0.
- cfg_valid, avl_in = 100, vtype_in = 7'b1_010_000 (SEW32) → vl = 4. Then avl_in = 3 → vl = 3. Then vsew = 5 → vill = 1, vl = 0.
- vl = 3, SEW32, v5 preset to all-ones; write wd = 0 to v5 → elements 0–2 are 0, element 3 is 0xFFFFFFFF.
- vl = 16, SEW8, v0 = 0x00FF; wmask_en = 1, write 0 to v7 (preset all-ones) → bytes 0–7 are 0, bytes 8–15 are 0xFF.
- issue_valid vd = 9 → busyA = 1 with raA = 9. A later wen to v9 together with issue_valid vd = 9 → busy stays 1. A wen alone → busy drops next cycle.
- With VREG_BYPASS_EN: wen wa = raA = 4, wd = 0xA5…, vl = max → rdA = wd in the same cycle. Without it: rdA shows the old value that cycle and wd the next.
